// File: rtl/bp_me_cce_trace_monitor_if.sv
// Tap and readout bundle for bp_me_cce_trace_monitor.
// A message moves on tap c when v_i[c] & accept_i[c]; a record leaves the buffer
// when entry_v_o & entry_yumi_i, and yumi is only raised while entry_v_o is high.
interface bp_me_cce_trace_monitor_if #(
    parameter int channels_p       = 5,
    parameter int addr_width_p     = 40,
    parameter int msg_type_width_p = 4,
    parameter int stamp_width_p    = 16,
    parameter int counter_width_p  = 32
);
    localparam int chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int rec_w  = stamp_width_p + chan_w + msg_type_width_p + addr_width_p;

    logic [channels_p-1:0]                  v_i;
    logic [channels_p-1:0]                  accept_i;
    logic [channels_p*addr_width_p-1:0]     addr_i;
    logic [channels_p*msg_type_width_p-1:0] msg_type_i;
    logic [channels_p-1:0]                  enable_mask_i;
    logic                                   wrap_mode_i;
    logic                                   clear_i;
    logic [rec_w-1:0]                       entry_o;
    logic                                   entry_v_o;
    logic                                   entry_yumi_i;
    logic [chan_w-1:0]                      count_sel_i;
    logic [counter_width_p-1:0]             count_o;
    logic [counter_width_p-1:0]             dropped_o;
    logic                                   overflow_o;
    logic [channels_p-1:0]                  stall_o;

    modport master (
        output v_i, accept_i, addr_i, msg_type_i, enable_mask_i, wrap_mode_i, clear_i,
               entry_yumi_i, count_sel_i,
        input  entry_o, entry_v_o, count_o, dropped_o, overflow_o, stall_o
    );

    modport slave (
        input  v_i, accept_i, addr_i, msg_type_i, enable_mask_i, wrap_mode_i, clear_i,
               entry_yumi_i, count_sel_i,
        output entry_o, entry_v_o, count_o, dropped_o, overflow_o, stall_o
    );
endinterface

// File: rtl/bp_me_cce_trace_monitor.sv
// Passive CCE channel monitor: per-channel event counters, time-stamped circular
// trace buffer with wrap/stop policy, dropped-event count and stall watchdogs.
module bp_me_cce_trace_monitor #(
    parameter int channels_p        = 5,
    parameter int addr_width_p      = 40,
    parameter int msg_type_width_p  = 4,
    parameter int els_p             = 16,
    parameter int stamp_width_p     = 16,
    parameter int counter_width_p   = 32,
    parameter int watchdog_cycles_p = 1024
) (
    input logic                     clk_i,
    input logic                     reset_n_i,
    bp_me_cce_trace_monitor_if.slave mon
);
    localparam int chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int rec_w  = stamp_width_p + chan_w + msg_type_width_p + addr_width_p;
    localparam int ptr_w  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int occ_w  = $clog2(els_p + 1);
    localparam int cnt_w  = $clog2(channels_p + 1);
    localparam int wd_w   = $clog2(watchdog_cycles_p + 1);
    localparam logic [wd_w-1:0]  wd_max   = wd_w'(watchdog_cycles_p);
    localparam logic [occ_w-1:0] occ_full = occ_w'(els_p);

    logic [stamp_width_p-1:0]   stamp_q;
    logic [ptr_w-1:0]           wptr_q, rptr_q;
    logic [occ_w-1:0]           occ_q, occ_next;
    logic [counter_width_p-1:0] counters_q [channels_p];
    logic [counter_width_p-1:0] dropped_q;
    logic                       overflow_q;
    logic [channels_p-1:0]      stall_q;
    logic [wd_w-1:0]            stall_cnt_q    [channels_p];
    logic [wd_w-1:0]            stall_cnt_next [channels_p];
    logic [rec_w-1:0]           mem [els_p];

    logic [channels_p-1:0]       hs, cand;
    logic [chan_w-1:0]           win_idx;
    logic [addr_width_p-1:0]     win_addr;
    logic [msg_type_width_p-1:0] win_msg;
    logic [cnt_w-1:0]            cand_cnt, drop_add;
    logic [counter_width_p:0]    drop_sum;
    logic                        wr_req, rd_pop, full, do_write, overwrite, drop_full;

    assign hs   = mon.v_i & mon.accept_i;
    assign cand = hs & mon.enable_mask_i & {channels_p{~mon.clear_i}};

    // Descending scan so the lowest-index candidate is the last one written.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_msg  = '0;
        cand_cnt = '0;
        for (int c = channels_p - 1; c >= 0; c--) begin
            if (cand[c]) begin
                win_idx  = chan_w'(c);
                win_addr = mon.addr_i[c*addr_width_p +: addr_width_p];
                win_msg  = mon.msg_type_i[c*msg_type_width_p +: msg_type_width_p];
                cand_cnt = cand_cnt + cnt_w'(1);
            end
        end
    end

    assign wr_req    = |cand;
    assign rd_pop    = mon.entry_yumi_i & (occ_q != '0) & ~mon.clear_i;
    assign full      = (occ_q == occ_full);
    assign do_write  = wr_req & (~full | rd_pop | mon.wrap_mode_i);
    assign overwrite = wr_req & full & ~rd_pop & mon.wrap_mode_i;
    assign drop_full = wr_req & full & ~rd_pop & ~mon.wrap_mode_i;
    assign drop_add  = cand_cnt - cnt_w'(wr_req) + cnt_w'(drop_full);
    assign drop_sum  = {1'b0, dropped_q} + (counter_width_p + 1)'(drop_add);

    always_comb begin
        occ_next = occ_q;
        if (do_write && !(rd_pop || overwrite)) occ_next = occ_q + occ_w'(1);
        else if (!do_write && rd_pop)           occ_next = occ_q - occ_w'(1);
    end

    // Stall counters restart whenever the channel is idle or handshakes.
    always_comb begin
        for (int c = 0; c < channels_p; c++) begin
            stall_cnt_next[c] = '0;
            if (mon.v_i[c] && !mon.accept_i[c])
                stall_cnt_next[c] = (stall_cnt_q[c] == wd_max) ? stall_cnt_q[c]
                                                                 : stall_cnt_q[c] + wd_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stamp_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            stall_q    <= '0;
            for (int c = 0; c < channels_p; c++) begin
                counters_q[c]  <= '0;
                stall_cnt_q[c] <= '0;
            end
        end else if (mon.clear_i) begin
            stamp_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            stall_q    <= '0;
            for (int c = 0; c < channels_p; c++) begin
                counters_q[c]  <= '0;
                stall_cnt_q[c] <= '0;
            end
        end else begin
            stamp_q <= stamp_q + stamp_width_p'(1);
            occ_q   <= occ_next;
            if (do_write)           wptr_q <= wptr_q + ptr_w'(1);
            if (rd_pop || overwrite) rptr_q <= rptr_q + ptr_w'(1);
            if (overwrite)          overflow_q <= 1'b1;
            dropped_q <= drop_sum[counter_width_p] ? '1 : drop_sum[counter_width_p-1:0];
            for (int c = 0; c < channels_p; c++) begin
                if (hs[c] && (counters_q[c] != '1))
                    counters_q[c] <= counters_q[c] + counter_width_p'(1);
                stall_cnt_q[c] <= stall_cnt_next[c];
                if (stall_cnt_next[c] == wd_max) stall_q[c] <= 1'b1;
            end
        end
    end

    // Storage has no reset; entry_o is gated by occupancy so stale data never shows.
    always_ff @(posedge clk_i) begin
        if (do_write) mem[wptr_q] <= {stamp_q, win_idx, win_msg, win_addr};
    end

    always_comb begin
        mon.count_o = '0;
        for (int c = 0; c < channels_p; c++)
            if (int'(mon.count_sel_i) == c) mon.count_o = counters_q[c];
    end

    assign mon.entry_v_o  = (occ_q != '0);
    assign mon.entry_o    = mon.entry_v_o ? mem[rptr_q] : '0;
    assign mon.dropped_o  = dropped_q;
    assign mon.overflow_o = overflow_q;
    assign mon.stall_o    = stall_q;
endmodule

// File: tb/tb_bp_me_cce_trace_monitor.sv
// Directed bench for bp_me_cce_trace_monitor with an expected-record queue.
module tb_bp_me_cce_trace_monitor;
    localparam int CH    = 5;
    localparam int AW    = 40;
    localparam int MW    = 4;
    localparam int ELS   = 16;
    localparam int SW    = 16;
    localparam int CW    = 32;
    localparam int WD    = 8;
    localparam int REC_W = SW + 3 + MW + AW;

    logic clk = 1'b0;
    logic reset_n;
    int n_checks = 0;
    int n_errors = 0;
    logic [SW-1:0]    tb_stamp;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] rec;

    bp_me_cce_trace_monitor_if #(
        .channels_p(CH), .addr_width_p(AW), .msg_type_width_p(MW),
        .stamp_width_p(SW), .counter_width_p(CW)
    ) bus ();

    bp_me_cce_trace_monitor #(
        .channels_p(CH), .addr_width_p(AW), .msg_type_width_p(MW), .els_p(ELS),
        .stamp_width_p(SW), .counter_width_p(CW), .watchdog_cycles_p(WD)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .mon(bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
        tb_stamp = tb_stamp + SW'(1);
    endtask

    task automatic idle_inputs();
        bus.v_i           = '0;
        bus.accept_i      = '0;
        bus.addr_i        = '0;
        bus.msg_type_i    = '0;
        bus.enable_mask_i = '1;
        bus.wrap_mode_i   = 1'b0;
        bus.clear_i       = 1'b0;
        bus.entry_yumi_i  = 1'b0;
        bus.count_sel_i   = '0;
    endtask

    task automatic do_clear();
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        tb_stamp = '0;
        exp_q.delete();
    endtask

    task automatic capture(input int ch, input logic [AW-1:0] a, input logic [MW-1:0] mt,
                           output logic [REC_W-1:0] r);
        bus.v_i[ch] = 1'b1;
        bus.accept_i[ch] = 1'b1;
        bus.addr_i[ch*AW +: AW] = a;
        bus.msg_type_i[ch*MW +: MW] = mt;
        r = {tb_stamp, 3'(ch), mt, a};
        step();
        bus.v_i = '0;
        bus.accept_i = '0;
    endtask

    task automatic read_count(input int ch, input logic [CW-1:0] exp, input string tag);
        bus.count_sel_i = 3'(ch);
        #1;
        check(tag, bus.count_o, exp);
    endtask

    // Scoreboard: pop n records and compare against exp_q, then expect empty
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check("drain_v", bus.entry_v_o, 1);
            check("drain_rec", bus.entry_o, exp_q.pop_front());
            bus.entry_yumi_i = 1'b1;
            step();
            bus.entry_yumi_i = 1'b0;
        end
        check("drain_empty", bus.entry_v_o, 0);
    endtask

    initial begin
        idle_inputs();
        tb_stamp = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_entry_v", bus.entry_v_o, 0);
        check("rst_entry", bus.entry_o, 0);
        check("rst_dropped", bus.dropped_o, 0);
        check("rst_stall", bus.stall_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tb_stamp = '0;

        // Single capture at stamp 5 on channel 2
        repeat (5) step();
        bus.v_i[2] = 1'b1;
        bus.accept_i[2] = 1'b1;
        bus.addr_i[2*AW +: AW] = 40'h80;
        bus.msg_type_i[2*MW +: MW] = 4'h3;
        #1;
        check("no_bypass", bus.entry_v_o, 0);
        step();
        bus.v_i = '0;
        bus.accept_i = '0;
        check("single_v", bus.entry_v_o, 1);
        check("single_rec", bus.entry_o, {16'd5, 3'd2, 4'h3, 40'h80});
        read_count(2, 1, "single_cnt2");
        bus.entry_yumi_i = 1'b1;
        step();
        bus.entry_yumi_i = 1'b0;
        check("single_pop", bus.entry_v_o, 0);

        // Simultaneous handshakes on 0, 1 and 3
        do_clear();
        bus.v_i = 5'b01011;
        bus.accept_i = 5'b01011;
        bus.addr_i[0 +: AW] = 40'h100;
        bus.addr_i[1*AW +: AW] = 40'h200;
        bus.addr_i[3*AW +: AW] = 40'h300;
        bus.msg_type_i[0 +: MW] = 4'h1;
        rec = {tb_stamp, 3'd0, 4'h1, 40'h100};
        step();
        bus.v_i = '0;
        bus.accept_i = '0;
        check("simul_dropped", bus.dropped_o, 2);
        check("simul_rec", bus.entry_o, rec);
        read_count(0, 1, "simul_cnt0");
        read_count(1, 1, "simul_cnt1");
        read_count(2, 0, "simul_cnt2");
        read_count(3, 1, "simul_cnt3");

        // Masked channel counts but is not captured or dropped
        do_clear();
        bus.enable_mask_i = 5'b11110;
        capture(0, 40'h55, 4'h7, rec);
        bus.enable_mask_i = '1;
        check("mask_v", bus.entry_v_o, 0);
        check("mask_dropped", bus.dropped_o, 0);
        read_count(0, 1, "mask_cnt0");

        // Handshake coincident with clear is ignored
        bus.clear_i = 1'b1;
        capture(1, 40'h66, 4'h1, rec);
        bus.clear_i = 1'b0;
        tb_stamp = '0;
        check("clrhs_v", bus.entry_v_o, 0);
        read_count(1, 0, "clrhs_cnt1");
        read_count(0, 0, "clrhs_cnt0");

        // Stop-on-full: 17 captures, the 17th is dropped
        do_clear();
        bus.wrap_mode_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            capture(0, AW'(i), 4'h2, rec);
            if (i < 16) exp_q.push_back(rec);
        end
        check("stop_dropped", bus.dropped_o, 1);
        check("stop_overflow", bus.overflow_o, 0);
        drain(16);

        // Wrap mode: 18 captures keep addr 2..17
        do_clear();
        bus.wrap_mode_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            capture(1, AW'(i), 4'h5, rec);
            if (i >= 2) exp_q.push_back(rec);
        end
        check("wrap_overflow", bus.overflow_o, 1);
        check("wrap_dropped", bus.dropped_o, 0);
        drain(16);
        bus.wrap_mode_i = 1'b0;

        // Push and pop in the same cycle while full
        do_clear();
        for (int i = 0; i < 16; i++) begin
            capture(3, AW'(i), 4'h9, rec);
            exp_q.push_back(rec);
        end
        check("pp_head", bus.entry_o, exp_q.pop_front());
        bus.entry_yumi_i = 1'b1;
        capture(3, 40'd16, 4'h9, rec);
        bus.entry_yumi_i = 1'b0;
        exp_q.push_back(rec);
        check("pp_dropped", bus.dropped_o, 0);
        check("pp_overflow", bus.overflow_o, 0);
        drain(16);

        // Watchdog on channel 4
        do_clear();
        bus.v_i[4] = 1'b1;
        repeat (WD - 1) step();
        check("wd_early", bus.stall_o, 0);
        step();
        check("wd_set", bus.stall_o, 5'b10000);
        repeat (3) step();
        check("wd_sticky", bus.stall_o, 5'b10000);
        read_count(4, 0, "wd_cnt4");
        bus.v_i = '0;
        do_clear();
        check("wd_clear", bus.stall_o, 0);

        // Reset in the middle of a burst
        bus.wrap_mode_i = 1'b1;
        for (int i = 0; i < 17; i++) capture(0, AW'(i), 4'h4, rec);
        check("pre_rst_overflow", bus.overflow_o, 1);
        read_count(0, 17, "pre_rst_cnt0");
        bus.v_i[0] = 1'b1;
        bus.accept_i[0] = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_entry_v", bus.entry_v_o, 0);
        check("mid_rst_entry", bus.entry_o, 0);
        check("mid_rst_count", bus.count_o, 0);
        check("mid_rst_dropped", bus.dropped_o, 0);
        check("mid_rst_overflow", bus.overflow_o, 0);
        check("mid_rst_stall", bus.stall_o, 0);
        idle_inputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        tb_stamp = '0;
        exp_q.delete();
        step();
        capture(2, 40'hABC, 4'hF, rec);
        check("post_rst_rec", bus.entry_o, {16'd1, 3'd2, 4'hF, 40'hABC});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bp_me_cce_trace_monitor.md
# bp_me_cce_trace_monitor

Synthesizable, parametrised successor to the CCE simulation tracer. It observes up to `channels_p` ME/LCE-CCE handshake channels and counts every accepted message per channel. It captures time-stamped message records into a circular on-chip trace buffer, with per-channel filtering and a selectable wrap or stop-on-full policy. It also flags channels whose valid is held without acceptance for too long. It sits beside the CCE, tapping the same valid/accept pairs, and is read out through a valid/yumi port by a debug or config agent.

## Interface
- `channels_p`, 5, number of observed channels (req, resp, cmd, mem_cmd, mem_resp by default)
- `addr_width_p`, 40, address field width per channel
- `msg_type_width_p`, 4, message type field width per channel
- `els_p`, 16, trace buffer depth; power of two, at least 2
- `stamp_width_p`, 16, timestamp width; free-running, wraps
- `counter_width_p`, 32, per-channel event counter width; saturating
- `watchdog_cycles_p`, 1024, stall threshold in cycles
- Record width is `stamp_width_p` + clog2(`channels_p`) + `msg_type_width_p` + `addr_width_p`. Fields are packed MSB→LSB as {stamp, chan, msg_type, addr}.
- `clk_i`  in  1  single clock; all state updates on posedge
- `reset_n_i`  in  1  asynchronous, active-low reset
- `v_i`  in  `channels_p`  per-channel message valid
- `accept_i`  in  `channels_p`  per-channel yumi/ready; a handshake is `v_i[c] & accept_i[c]`
- `addr_i`  in  `channels_p*addr_width_p`  per-channel header address
- `msg_type_i`  in  `channels_p*msg_type_width_p`  per-channel header msg_type
- `enable_mask_i`  in  `channels_p`  1 = channel eligible for capture (counting is unaffected)
- `wrap_mode_i`  in  1  1 = overwrite oldest entry when full; 0 = drop new entries when full
- `clear_i`  in  1  synchronous flush of buffer, counters, flags and timestamp
- `entry_o`  out  record width  oldest buffered record
- `entry_v_o`  out  1  `entry_o` is valid
- `entry_yumi_i`  in  1  consumes `entry_o`; legal only when `entry_v_o` is high
- `count_sel_i`  in  clog2(`channels_p`)  selects which counter drives `count_o`
- `count_o`  out  `counter_width_p`  selected channel's event count (combinational mux of registers)
- `dropped_o`  out  `counter_width_p`  saturating count of handshakes lost to arbitration or a full buffer
- `overflow_o`  out  1  sticky; set when any entry was overwritten in wrap mode
- `stall_o`  out  `channels_p`  sticky per-channel watchdog flags

## Operation
- **Counting:** every handshake on channel c increments `counter[c]`, regardless of `enable_mask_i`. Counters saturate at all-ones.
- **Capture candidates:** the handshaking channels with their mask bit set. The lowest index wins; one record is written per cycle at most.
- **Losing candidates:** each losing candidate increments `dropped_o` by 1. Multiple losers in one cycle add their population count, saturating.
- **Record contents:** {current stamp, winning channel index, msg_type, addr} of the winner.
- **Buffer:** circular, with write pointer, read pointer and occupancy count (0..`els_p`).
- **Full, `wrap_mode_i`=1:** the write proceeds, the read pointer advances (oldest entry discarded), occupancy is unchanged and `overflow_o` is set.
- **Full, `wrap_mode_i`=0:** the record is not written and `dropped_o` increments by 1.
- **Full with `entry_yumi_i` in the same cycle:** the pop frees a slot, so the write succeeds in either mode. There is no overwrite, no drop, and occupancy is unchanged.
- **Empty with a write in the same cycle:** `entry_v_o` stays low that cycle; no bypass path.
- **Watchdog:** each channel has a stall counter, clog2(`watchdog_cycles_p`+1) bits wide.
  - It increments while `v_i[c]` is high and `accept_i[c]` is low, and holds at its maximum.
  - It resets to 0 on a handshake or when `v_i[c]` is low.
  - `stall_o[c]` is set when the counter reaches `watchdog_cycles_p`.
- **`clear_i`:** zeroes the pointers, occupancy, all counters, `dropped_o`, `overflow_o`, `stall_o`, stall counters and the stamp. A handshake in the same cycle as `clear_i` is neither counted nor captured.
- **`wrap_mode_i` changes:** may change at any time; it is sampled in the cycle of the write.

## Timing
- **Reset values (`reset_n_i` low, asynchronous):**
  - `entry_v_o`=0, `entry_o`=0, `count_o`=0, `dropped_o`=0, `overflow_o`=0, `stall_o`=0.
  - Stamp=0, pointers=0.
  - Buffer storage contents are undefined but never visible.
- **Deassertion:** reset deassertion is taken as synchronous to `clk_i` by the integrator. The first edge after deassertion increments the stamp to 1.
- **Stamp:** increments every cycle and wraps modulo 2^`stamp_width_p`. The recorded stamp is the value during the handshake cycle.
- **Capture latency:** a handshake in cycle N is visible on `entry_o`/`entry_v_o` in cycle N+1 at the earliest.
- **Counter latency:** counters reflect a cycle-N handshake from cycle N+1.
- **Pop:** `entry_yumi_i` in cycle N presents the next entry, or `entry_v_o`=0, in cycle N+1.
- **Stall flag:** `v_i` high and unaccepted from cycle N sets `stall_o` in cycle N+`watchdog_cycles_p`.
- **Outputs:** all are registers or muxes of registers; no input-to-output combinational path except `count_sel_i`→`count_o`.

## Test plan
- **Single capture:** reset, then one handshake on channel 2 at stamp 5 with addr 0x80, msg_type 0x3 → the next cycle `entry_v_o`=1 with record {5, 2, 3, 0x80}; `count_sel_i`=2 gives `count_o`=1.
- **Simultaneous handshakes:** channels 0, 1 and 3 handshake in the same cycle with all masks set → only channel 0 is captured; `dropped_o`=2; counters 0, 1 and 3 each read 1.
- **Stop-on-full:** `wrap_mode_i`=0, `els_p`=16, 17 captures with no pops → the 16 oldest records remain; `dropped_o`=1; `overflow_o`=0.
- **Wrap mode:** `wrap_mode_i`=1, 18 captures with addr 0..17 → readout yields addr 2..17 in order; `overflow_o`=1.
- **Push/pop when full:** buffer full, with push and pop in the same cycle → occupancy stays 16; `dropped_o` and `overflow_o` are unchanged.
- **Watchdog and clear:** `watchdog_cycles_p`=8, `v_i[4]` held high with `accept_i[4]` low → `stall_o[4]` rises exactly 8 cycles after the first valid cycle. A later `clear_i` zeroes it.
- **Reset mid-operation:** assert `reset_n_i` low mid-burst → all outputs read 0 immediately, before any clock edge.
